button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//   Input conditioning stage for the push-buttons feeding the system's buttons_export PIO.
//   Per button: synchronises the raw active-low key, debounces it, and exports a clean level.
//   Also produces one-cycle press/release pulses for the PIO edge-capture logic.
//   Sits between the board KEY pins and buttons_export; all outputs are registered.
// PARAMETERS
//   NUM_BTN         4          number of independent button channels
//   SYNC_STAGES     2          synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES 1_000_000  cycles input must stay stable to accept a change (20 ms @ 50 MHz, >=2)
//   REPEAT_DELAY    25_000_000 cycles held before first auto-repeat pulse (BTN_AUTOREPEAT_EN only)
//   REPEAT_PERIOD   5_000_000  cycles between subsequent auto-repeat pulses (BTN_AUTOREPEAT_EN only)
// PORTS
//   clk_clk          in   1        system clock
//   reset_reset_n    in   1        asynchronous active-low reset
//   btn_raw_n        in   NUM_BTN  raw keys, active low, asynchronous to clk_clk
//   buttons_export   out  NUM_BTN  debounced level, active low (1 = released)
//   press_pulse      out  NUM_BTN  1-cycle strobe on accepted press (and on auto-repeats)
//   release_pulse    out  NUM_BTN  1-cycle strobe on accepted release
//   any_press        out  1        OR of press_pulse, same cycle
// BEHAVIOUR
//   - Reset (async assert, sync release): synchroniser flops = 1, buttons_export = all 1,
//     pulses = 0, any_press = 0, counters = 0, every channel in UP.
//   - Per-channel FSM on synchronised input s: UP, WAIT_DOWN, DOWN, WAIT_UP.
//     UP: s=0 -> WAIT_DOWN, counter cleared. WAIT_DOWN: s=1 -> UP (glitch rejected, no pulse);
//     counter reaches DEBOUNCE_CYCLES-1 with s=0 -> DOWN, buttons_export bit=0, press_pulse=1.
//     DOWN: s=1 -> WAIT_UP. WAIT_UP: s=0 -> DOWN (no pulse); counter reaches DEBOUNCE_CYCLES-1
//     with s=1 -> UP, buttons_export bit=1, release_pulse=1.
//   - Latency: clean edge on btn_raw_n -> level/pulse change exactly SYNC_STAGES+DEBOUNCE_CYCLES
//     cycles after first clock edge sampling the new value.
//   - Counter width $clog2(DEBOUNCE_CYCLES); saturates never (cleared on every state entry).
//   - Bounce shorter than DEBOUNCE_CYCLES restarts acceptance; output never toggles on it.
//   - Channels fully independent; simultaneous presses give simultaneous pulses; any_press=1 once.
//   - press_pulse and release_pulse of one channel never assert in the same cycle.
//   - Reset mid-debounce discards the pending transition; no pulse emitted after release of reset.
// CONFIGURATION
//   BTN_AUTOREPEAT_EN defined: in DOWN a repeat counter runs; press_pulse re-fires REPEAT_DELAY
//     cycles after the accepted press, then every REPEAT_PERIOD cycles while still DOWN;
//     repeat counter cleared on any exit from DOWN (WAIT_UP re-entering DOWN restarts delay).
//   Not defined: exactly one press_pulse per accepted press; repeat counter logic absent.
// STRUCTURE
//   Package btn_pkg: typedef enum logic [1:0] btn_state_t {UP, WAIT_DOWN, DOWN, WAIT_UP};
//     localparam function for counter widths.
//   Sub-module btn_debounce_ch: one channel (synchroniser, FSM, counters, pulses);
//     button_conditioner instantiates NUM_BTN copies via generate and ORs any_press.
// TESTING (bench uses DEBOUNCE_CYCLES=8, SYNC_STAGES=2, REPEAT_DELAY=40, REPEAT_PERIOD=10)
//   1. Reset, raw=4'hF held -> buttons_export=4'hF, no pulses for 100 cycles.
//   2. raw[0] 1->0 clean -> press_pulse[0] high exactly 10 cycles later for 1 cycle, export=4'hE;
//      raw[0] back to 1 -> release_pulse[0] 10 cycles later, export=4'hF.
//   3. raw[1] bounces low 5 cycles/high 3 cycles x4, then low -> single press_pulse[1],
//      10 cycles after final falling edge; no pulse during bounce.
//   4. raw[2] and raw[3] fall same cycle -> press_pulse=4'hC one cycle, any_press=1 one cycle.
//   5. Assert reset_reset_n=0 at 5th cycle of WAIT_DOWN on ch0 -> export=4'hF immediately,
//      after reset release with raw[0] still 0: press accepted only after full 10-cycle latency.
//   6. BTN_AUTOREPEAT_EN, hold raw[0] low 100 cycles -> press_pulse[0] at t, t+40, t+50, t+60...;
//      without macro -> only at t.

Source files
------------

// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
//   Shared types and elaboration helpers for the push-button conditioner.
//   Contents:
//     btn_state_t  per-channel debounce state (UP, WAIT_DOWN, DOWN, WAIT_UP)
//     cnt_width()  bits needed for a counter that runs 0 .. n-1
//     max2()       larger of two integers, for sizing shared counters
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,  // debounced released, input agrees
    WAIT_DOWN = 2'd1,  // released, input low, qualifying the press
    DOWN      = 2'd2,  // debounced pressed, input agrees
    WAIT_UP   = 2'd3   // pressed, input high, qualifying the release
  } btn_state_t;

  // A counter that must hold values 0 .. n-1 needs $clog2(n) bits; keep at
  // least one bit so degenerate settings still elaborate.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// ---------------------------------------------------------------------------
// btn_debounce_ch
//   One push-button channel: synchroniser, four-state debounce FSM,
//   stability counter, registered level and one-cycle press/release strobes.
//   Optional feature macro: BTN_AUTOREPEAT_EN -- when defined, a repeat
//   counter re-fires press_pulse while the button stays down.
//
// Ports
//   clk           in   1  clock
//   rst_n         in   1  asynchronous active-low reset
//   raw_n         in   1  raw key, active low, asynchronous to clk
//   level         out  1  debounced level, active low (1 = released)
//   press_pulse   out  1  registered strobe on accepted press / auto-repeat
//   release_pulse out  1  registered strobe on accepted release
//   press_arm     out  1  value press_pulse takes at the next edge; lets the
//                         parent register an OR of all channels in step
//
// Timing: a clean edge on raw_n shows up on level/pulses exactly
// SYNC_STAGES + DEBOUNCE_CYCLES edges after the first edge that samples it.
// ---------------------------------------------------------------------------
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_arm
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Synchroniser. Resets to "released" so a reset never fakes a press edge.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_n};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Debounce FSM
  // -------------------------------------------------------------------------
  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cnt_done;
  logic             press_accept;
  logic             release_accept;
  logic             repeat_fire;
  logic             level_next;

  assign cnt_done = (cnt_reg == CNT_LAST);

  // State register, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= UP;
      cnt_reg       <= '0;
      level         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      level         <= level_next;
      press_pulse   <= press_arm;
      release_pulse <= release_accept;
    end
  end

  // Next-state logic. The counter only runs in the two WAIT states and is
  // zero everywhere else, so every state entry starts it from zero; it can
  // never pass CNT_LAST because reaching CNT_LAST either leaves the state or
  // the input has already disagreed.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      UP: begin
        if (!s) begin
          state_next = WAIT_DOWN;
        end
      end
      WAIT_DOWN: begin
        if (s) begin
          state_next = UP;             // bounce: drop back, no pulse
        end else if (cnt_done) begin
          state_next = DOWN;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DOWN: begin
        if (s) begin
          state_next = WAIT_UP;
        end
      end
      WAIT_UP: begin
        if (!s) begin
          state_next = DOWN;           // bounce: still pressed, no pulse
        end else if (cnt_done) begin
          state_next = UP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = UP;
      end
    endcase
  end

  // Output logic: decides what the output registers load at this edge.
  // Press and release come from different states, so they are exclusive.
  always_comb begin
    press_accept   = 1'b0;
    release_accept = 1'b0;
    level_next     = level;
    case (state_reg)
      WAIT_DOWN: begin
        if (!s && cnt_done) begin
          press_accept = 1'b1;
          level_next   = 1'b0;
        end
      end
      WAIT_UP: begin
        if (s && cnt_done) begin
          release_accept = 1'b1;
          level_next     = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign press_arm = press_accept | repeat_fire;

`ifdef BTN_AUTOREPEAT_EN
  // -------------------------------------------------------------------------
  // Auto-repeat. The counter runs only while the FSM stays in DOWN with the
  // input still low; any other edge (including the one entering DOWN)
  // clears it and re-arms the longer first delay. Cycle t of the accepted
  // press holds count 0, so a fire at count LIMIT lands the strobe exactly
  // LIMIT+1 cycles later, hence the "-1" limits.
  // -------------------------------------------------------------------------
  localparam int               RPT_W     = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic [RPT_W-1:0] rpt_limit;
  logic             rpt_first_reg, rpt_first_next;

  assign rpt_limit = rpt_first_reg ? RPT_FIRST : RPT_NEXT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_reg   <= '0;
      rpt_first_reg <= 1'b1;
    end else begin
      rpt_cnt_reg   <= rpt_cnt_next;
      rpt_first_reg <= rpt_first_next;
    end
  end

  always_comb begin
    rpt_cnt_next   = '0;
    rpt_first_next = 1'b1;
    repeat_fire    = 1'b0;
    if (state_reg == DOWN && !s) begin
      if (rpt_cnt_reg == rpt_limit) begin
        repeat_fire    = 1'b1;
        rpt_first_next = 1'b0;
      end else begin
        rpt_cnt_next   = rpt_cnt_reg + RPT_W'(1);
        rpt_first_next = rpt_first_reg;
      end
    end
  end
`else
  // Without auto-repeat a press produces exactly one strobe.
  assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Conditions the board KEY pins before the buttons_export PIO: each button
//   is synchronised and debounced independently; the block exports the clean
//   level and one-cycle press/release strobes for edge capture. All outputs
//   are registered.
//   Optional feature macro: BTN_AUTOREPEAT_EN -- enables press auto-repeat
//   (REPEAT_DELAY / REPEAT_PERIOD only take effect when it is defined).
//   Reset asserts asynchronously; its release is expected to be synchronous
//   to clk_clk (provided by the system reset controller).
//
// Ports
//   clk_clk         in   1        system clock
//   reset_reset_n   in   1        asynchronous active-low reset
//   btn_raw_n       in   NUM_BTN  raw keys, active low, asynchronous
//   buttons_export  out  NUM_BTN  debounced level, active low (1 = released)
//   press_pulse     out  NUM_BTN  1-cycle strobe on accepted press / repeat
//   release_pulse   out  NUM_BTN  1-cycle strobe on accepted release
//   any_press       out  1        OR of press_pulse, same cycle
// ---------------------------------------------------------------------------
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [NUM_BTN-1:0] btn_raw_n,
  output logic [NUM_BTN-1:0] buttons_export,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic               any_press
);

  // Refuse to build with settings the channel logic cannot honour.
  if (NUM_BTN < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: invalid parameter set");
  end

  logic [NUM_BTN-1:0] press_arm;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk           (clk_clk),
      .rst_n         (reset_reset_n),
      .raw_n         (btn_raw_n[gi]),
      .level         (buttons_export[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .press_arm     (press_arm[gi])
    );
  end

  // Registered from the channels' next-cycle strobes so it lines up with
  // press_pulse while still being a flop output.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_arm;
    end
  end

endmodule
